// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage with IF/ID register and one-entry skid buffer.
//
// Holds the fetch PC, issues instruction-memory reads and loads the IF/ID
// pipeline register. When decode stalls while a read completes, the returned
// word is parked in a skid buffer (HOLD state) and the request is dropped until
// decode frees up. A taken branch from the memory stage overrides everything.
//
// Parameters:
//   RESET_PC      PC value loaded on reset.
// Optional feature:
//   FETCH_STALL_CNT_EN  when defined, stall_cnt counts stall and bubble cycles
//                       (saturating); otherwise stall_cnt is tied to zero.
//
// Ports:
//   clk           clock, all state updates on rising edge
//   reset         synchronous active-high reset
//   imem_req      instruction-memory read request (1 in FETCH, 0 in HOLD)
//   imem_addr     read address (= pc_F)
//   imem_rdata    instruction word, valid when imem_ready=1
//   imem_ready    read data valid this cycle for imem_addr
//   stall_DEC     decode cannot accept a new instruction
//   pcsrc_MEM     branch taken (memory stage)
//   pcbranch_MEM  branch target
//   pc_F          current fetch PC
//   instr_DEC     IF/ID instruction register
//   opcode        instr_DEC[31:26]
//   funct         instr_DEC[5:0]
//   pcplus4_DEC   PC+4 of the instruction in instr_DEC
//   valid_DEC     instr_DEC holds a real instruction
//   stall_cnt     stall/bubble cycle counter

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall_DEC,
   input  logic        pcsrc_MEM,
   input  logic [31:0] pcbranch_MEM,
   output logic [31:0] pc_F,
   output logic [31:0] instr_DEC,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [31:0] pcplus4_DEC,
   output logic        valid_DEC,
   output logic [31:0] stall_cnt
);

   typedef enum logic [0:0] {StFetch, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcplus4_q, pcplus4_d;
   logic        valid_q, valid_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pcplus4_q, skid_pcplus4_d;

   logic [31:0] pc_plus4;
   logic        bubble;

   // Modulo-2^32 by construction of the 32-bit add.
   assign pc_plus4 = pc_q + 32'd4;

   // Bubble: fetching, no data, decode ready, no redirect overriding it.
   assign bubble = (state_q == StFetch) && !imem_ready && !stall_DEC && !pcsrc_MEM;

   //---------------------------------------------------------------------------
   // State registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StFetch;
         pc_q           <= RESET_PC;
         instr_q        <= '0;
         pcplus4_q      <= '0;
         valid_q        <= 1'b0;
         skid_instr_q   <= '0;
         skid_pcplus4_q <= '0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         instr_q        <= instr_d;
         pcplus4_q      <= pcplus4_d;
         valid_q        <= valid_d;
         skid_instr_q   <= skid_instr_d;
         skid_pcplus4_q <= skid_pcplus4_d;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      instr_d        = instr_q;
      pcplus4_d      = pcplus4_q;
      valid_d        = valid_q;
      skid_instr_d   = skid_instr_q;
      skid_pcplus4_d = skid_pcplus4_q;

      if (pcsrc_MEM) begin
         // Redirect wins over stall; any returned or buffered word is dropped.
         state_d        = StFetch;
         pc_d           = pcbranch_MEM;
         instr_d        = '0;
         pcplus4_d      = '0;
         valid_d        = 1'b0;
         skid_instr_d   = '0;
         skid_pcplus4_d = '0;
      end else begin
         unique case (state_q)
            StFetch: begin
               if (imem_ready && !stall_DEC) begin
                  instr_d   = imem_rdata;
                  pcplus4_d = pc_plus4;
                  valid_d   = 1'b1;
                  pc_d      = pc_plus4;
               end else if (imem_ready && stall_DEC) begin
                  // Decode busy: park the word, IF/ID and PC hold.
                  skid_instr_d   = imem_rdata;
                  skid_pcplus4_d = pc_plus4;
                  state_d        = StHold;
               end else if (!imem_ready && !stall_DEC) begin
                  instr_d = '0;
                  valid_d = 1'b0;
               end
               // !imem_ready && stall_DEC: everything holds.
            end
            StHold: begin
               if (!stall_DEC) begin
                  instr_d   = skid_instr_q;
                  pcplus4_d = skid_pcplus4_q;
                  valid_d   = 1'b1;
                  pc_d      = skid_pcplus4_q;
                  state_d   = StFetch;
               end
            end
            default: begin
               state_d = StFetch;
            end
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign imem_req    = (state_q == StFetch);
   assign imem_addr   = pc_q;
   assign pc_F        = pc_q;
   assign instr_DEC   = instr_q;
   assign pcplus4_DEC = pcplus4_q;
   assign valid_DEC   = valid_q;
   assign opcode      = instr_q[31:26];
   assign funct       = instr_q[5:0];

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if ((stall_DEC || bubble) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'd0;

   // Bubble detect only feeds the counter.
   logic unused_bubble;
   assign unused_bubble = bubble;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 32, read address, equal to pc_F.
REQ-006 SHALL have port imem_rdata, input, 32, instruction word, valid when imem_ready=1.
REQ-007 SHALL have port imem_ready, input, 1, read data valid this cycle for the current imem_addr.
REQ-008 SHALL have port stall_DEC, input, 1, decode stage cannot accept a new instruction.
REQ-009 SHALL have port pcsrc_MEM, input, 1, branch taken, resolved in the memory stage.
REQ-010 SHALL have port pcbranch_MEM, input, 32, branch target.
REQ-011 SHALL have port pc_F, output, 32, current fetch PC.
REQ-012 SHALL have port instr_DEC, output, 32, IF/ID instruction register.
REQ-013 SHALL have port opcode, output, 6, instr_DEC[31:26], driving the controller.
REQ-014 SHALL have port funct, output, 6, instr_DEC[5:0], driving the controller.
REQ-015 SHALL have port pcplus4_DEC, output, 32, PC+4 of the instruction in instr_DEC.
REQ-016 SHALL have port valid_DEC, output, 1, instr_DEC holds a real instruction.
REQ-017 SHALL have port stall_cnt, output, 32, stall/bubble cycle counter (see Configuration).

Function
REQ-018 SHALL implement a two-state FSM: FETCH (request outstanding) and HOLD (word captured in skid buffer, decode stalled).
REQ-019 In FETCH, imem_req SHALL be 1; in HOLD, imem_req SHALL be 0.
REQ-020 In FETCH with imem_ready=1 and stall_DEC=0: instr_DEC<=imem_rdata, pcplus4_DEC<=pc_F+4, valid_DEC<=1, pc_F<=pc_F+4; stay in FETCH.
REQ-021 In FETCH with imem_ready=1 and stall_DEC=1: the skid buffer SHALL capture imem_rdata and pc_F+4; IF/ID holds; pc_F holds; next state HOLD.
REQ-022 In FETCH with imem_ready=0 and stall_DEC=0: a bubble SHALL be inserted (instr_DEC<=0, valid_DEC<=0); pc_F holds.
REQ-023 When stall_DEC=1 and no redirect occurs, IF/ID (instr_DEC, pcplus4_DEC, valid_DEC) SHALL hold its value.
REQ-024 In HOLD with stall_DEC=0: the skid buffer SHALL move into IF/ID with valid_DEC<=1, pc_F<=buffered PC+4, and the next state SHALL be FETCH.
REQ-025 pcsrc_MEM=1 SHALL take priority over all other conditions, including stall_DEC: pc_F<=pcbranch_MEM, instr_DEC<=0, valid_DEC<=0, skid buffer discarded, next state FETCH; imem_rdata that cycle is dropped.
REQ-026 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-027 The fetch-to-decode latency SHALL be one cycle from the imem_ready=1 edge to the instruction appearing in instr_DEC.
REQ-028 opcode and funct SHALL be combinational slices of instr_DEC.

Reset
REQ-029 On reset: pc_F=RESET_PC, instr_DEC=0, pcplus4_DEC=0, valid_DEC=0, skid buffer=0, state=FETCH, stall_cnt=0.
REQ-030 Reset SHALL override pcsrc_MEM and stall_DEC, and SHALL abort HOLD mid-operation with no instruction delivered.

Configuration
REQ-031 Macro FETCH_STALL_CNT_EN: when defined, stall_cnt SHALL increment every non-reset cycle in which stall_DEC=1 or a bubble is inserted per REQ-022, saturating at 32'hFFFF_FFFF; when undefined, stall_cnt SHALL be constant 0 and no counter logic is generated.

Verification
REQ-032 Reset then imem_ready=1 continuously with words A,B,C -> instr_DEC=A,B,C on cycles 1,2,3; pc_F=0,4,8,12.
REQ-033 imem_ready=0 for 2 cycles at pc 0x10 -> two bubbles (valid_DEC=0, instr_DEC=0), pc_F stays at 0x10, then the word appears.
REQ-034 stall_DEC=1 for 3 cycles with word D returned -> HOLD, imem_req=0, IF/ID unchanged; after stall_DEC=0, D appears with pcplus4_DEC=pc+4, without loss or duplication.
REQ-035 pcsrc_MEM=1, pcbranch_MEM=0x40 while in HOLD with stall_DEC=1 -> next cycle pc_F=0x40, valid_DEC=0, FETCH; the buffered word is never delivered.
REQ-036 RESET_PC=32'hFFFF_FFFC, one fetch -> pc_F wraps to 0, pcplus4_DEC=0.
REQ-037 With FETCH_STALL_CNT_EN defined: 5 stall cycles plus 2 bubbles -> stall_cnt=7; without the macro -> stall_cnt=0.
